// File: rtl/blueintegral_mat_pkg.sv
// blueintegral_mat_pkg: opcodes, FSM state type and result-encoding helpers for the matrix sequencer
//   bool4 : 8-bit result (2 bits per entry) -> 4-bit 0/1 matrix {M00,M01,M10,M11}
//   widen : 4-bit 0/1 matrix -> 8-bit result encoding
package blueintegral_mat_pkg;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_POW  = 2'b01;
    localparam logic [1:0] OP_BOOL = 2'b10;
    localparam logic [1:0] OP_STAT = 2'b11;
    localparam logic [7:0] IDENT   = 8'h41;
    typedef enum logic [1:0] {IDLE, WAIT_OP, COMPUTE, OUT} state_e;
    function automatic logic [3:0] bool4(input logic [7:0] r);
        return {|r[7:6], |r[5:4], |r[3:2], |r[1:0]};
    endfunction
    function automatic logic [7:0] widen(input logic [3:0] m);
        return {1'b0, m[3], 1'b0, m[2], 1'b0, m[1], 1'b0, m[0]};
    endfunction
endpackage

// File: rtl/blueintegral_mat_mult.sv
// blueintegral_mat_mult: combinational 2x2 binary matrix product C = A*B
//   ab_i : {A00,A01,A10,A11, B00,B01,B10,B11}
//   c_o  : {C00,C01,C10,C11}, 2 bits per entry, values 0..2
module blueintegral_mat_mult (
    input  logic [7:0] ab_i,
    output logic [7:0] c_o
);
    assign c_o = {2'(ab_i[7] & ab_i[3]) + 2'(ab_i[6] & ab_i[1]),
                  2'(ab_i[7] & ab_i[2]) + 2'(ab_i[6] & ab_i[0]),
                  2'(ab_i[5] & ab_i[3]) + 2'(ab_i[4] & ab_i[1]),
                  2'(ab_i[5] & ab_i[2]) + 2'(ab_i[4] & ab_i[0])};
endmodule

// File: rtl/blueintegral_mat_ctrl.sv
// blueintegral_mat_ctrl: job sequencer around blueintegral_mat_mult (MUL / BOOL / POW, optional STAT)
//   clk, reset          : clock, synchronous active-high reset
//   in_data/valid/ready : command byte then operand byte
//   out_data/valid/ready: result byte {C00,C01,C10,C11}
//   busy                : state != IDLE
//   err                 : one-cycle pulse after an illegal command
//   MAT_CTRL_STATS_EN   : enables the job counter and the STAT opcode
module blueintegral_mat_ctrl
    import blueintegral_mat_pkg::*;
#(
    parameter int EXP_W = 3,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);
    state_e state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [EXP_W-1:0] k_q, k_d, iter_q, iter_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [7:0] res_q, res_d, prod;
    logic err_q, err_d;
    logic pow;
`ifdef MAT_CTRL_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (state_q == OUT && out_ready && op_q != OP_STAT) cnt_q <= cnt_q + 1'b1;
    end
`endif
    assign pow = op_q == OP_POW;
    // POW keeps its running 0/1 accumulator in res_q and multiplies it by A each pass
    blueintegral_mat_mult u_mult (
        .ab_i({pow ? bool4(res_q) : a_q, pow ? a_q : b_q}),
        .c_o (prod)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            k_q     <= '0;
            iter_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            iter_q  <= iter_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
    // COMPUTE runs one pass per cycle while iter != 0, then spends one cycle moving to OUT
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        iter_d  = iter_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = in_data[7:6];
                k_d  = in_data[EXP_W-1:0];
`ifdef MAT_CTRL_STATS_EN
                state_d = in_data[7:6] == OP_STAT ? OUT : WAIT_OP;
                if (in_data[7:6] == OP_STAT) res_d = 8'(cnt_q);
`else
                state_d = in_data[7:6] == OP_STAT ? IDLE : WAIT_OP;
                err_d   = in_data[7:6] == OP_STAT;
`endif
            end
            WAIT_OP: if (in_valid) begin
                state_d = COMPUTE;
                a_d     = in_data[7:4];
                b_d     = in_data[3:0];
                iter_d  = !pow ? EXP_W'(1) : k_q == '0 ? '0 : k_q - 1'b1;
                res_d   = k_q == '0 ? IDENT : widen(in_data[7:4]);
            end
            COMPUTE: if (iter_q == '0) state_d = OUT;
            else begin
                iter_d = iter_q - 1'b1;
                res_d  = op_q == OP_MUL ? prod : widen(bool4(prod));
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = state_q == IDLE || state_q == WAIT_OP;
        out_valid = state_q == OUT;
        busy      = state_q != IDLE;
        out_data  = res_q;
        err       = err_q;
    end
endmodule
